// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the LO value written by a divide by zero.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    // Every LO bit is set on a divide by zero; replicated to WIDTH by the user.
    localparam logic MDU_DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: res = neg ? (~val + cin) : val.
// cin lets two instances negate a double-width value half by half.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        if (neg_i) begin
            res_o = ~val_i + WIDTH'(cin_i);
        end else begin
            res_o = val_i;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (radix-2, WIDTH steps).
// Define MDU_EARLY_TERM_EN to let multiplies leave CALC once the multiplier is exhausted.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dzo_q, dzo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               s1_neg, s2_neg;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH:0]     rem_diff;
    logic               hi_neg, hi_cin;
    logic [WIDTH-1:0]   fix_lo, fix_hi;

    assign s1_neg = op_i[0] & src1_i[WIDTH-1];
    assign s2_neg = op_i[0] & src2_i[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs1 (
        .neg_i (s1_neg),
        .cin_i (1'b1),
        .val_i (src1_i),
        .res_o (abs1)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs2 (
        .neg_i (s2_neg),
        .cin_i (1'b1),
        .val_i (src2_i),
        .res_o (abs2)
    );

    // Both op classes keep their low result (LO product / quotient) in acc_q low
    // and the high result (HI product / remainder) in acc_q high.
    assign hi_neg = is_div_q ? rneg_q : neg_q;
    assign hi_cin = is_div_q ? 1'b1 : (acc_q[WIDTH-1:0] == '0);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_lo (
        .neg_i (neg_q),
        .cin_i (1'b1),
        .val_i (acc_q[WIDTH-1:0]),
        .res_o (fix_lo)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_hi (
        .neg_i (hi_neg),
        .cin_i (hi_cin),
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .res_o (fix_hi)
    );

    // Restoring divide step: shifted partial remainder is WIDTH+1 bits wide.
    assign rem_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff  = rem_trial - {1'b0, mplier_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        dzo_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (hi_we_i) begin
            hi_d = wdata_i;
        end
        if (lo_we_i) begin
            lo_d = wdata_i;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op_i[1];
                    neg_d    = s1_neg ^ s2_neg;
                    mplier_d = abs2;
                    if (op_i[1]) begin
                        rneg_d  = s1_neg;
                        dz_d    = (src2_i == '0);
                        mcand_d = {{WIDTH{1'b0}}, src1_i};
                        acc_d   = {{WIDTH{1'b0}}, abs1};
                    end else begin
                        rneg_d  = 1'b0;
                        dz_d    = 1'b0;
                        mcand_d = {{WIDTH{1'b0}}, abs1};
                        acc_d   = '0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!rem_diff[WIDTH]) begin
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d = FIX;
                end
`ifdef MDU_EARLY_TERM_EN
                else if (!is_div_q && (mplier_d == '0)) begin
                    state_d = FIX;
                end
`endif
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                if (dz_q) begin
                    hi_d = mcand_q[WIDTH-1:0];
                    lo_d = {WIDTH{MDU_DIV0_LO_BIT}};
                end else begin
                    hi_d = fix_hi;
                    lo_d = fix_lo;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dzo_q    <= dzo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dzo_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32), immediate assertions.
// Honours MDU_EARLY_TERM_EN for the early-termination latency check.
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .hi_we_i    (hi_we_i),
        .lo_we_i    (lo_we_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait (bounded) until busy_o drops; report busy cycles and
    // the done/div_zero levels in the cycle right after.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output logic dn, output logic dz);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
        bcyc    = 0;
        while (busy_o && bcyc < 100) begin
            bcyc++;
            @(negedge clk_i);
        end
        dn = done_o;
        dz = div_zero_o;
        $display("op=%0d src1=%h src2=%h busy_cycles=%0d done=%0b dz=%0b hi=%h lo=%h",
                 op, a, b, bcyc, dn, dz, hi_o, lo_o);
    endtask

    int   bc;
    logic dn, dz;
    int   dcount;
    int   exp_et_cycles;

    initial begin
        #1;
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);
        check("reset_dz",   {63'd0, div_zero_o}, 64'd0);
        check("reset_hi",   {32'd0, hi_o}, 64'd0);
        check("reset_lo",   {32'd0, lo_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dn, dz);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        check("multu_done", {63'd0, dn}, 64'd1);
        check("multu_dz", {63'd0, dz}, 64'd0);
        check("multu_hi", {32'd0, hi_o}, 64'h00000000FFFFFFFE);
        check("multu_lo", {32'd0, lo_o}, 64'h0000000000000001);
        @(negedge clk_i);
        check("multu_done_one_cycle", {63'd0, done_o}, 64'd0);

        run_op(2'b01, 32'hFFFFFFFD, 32'd7, bc, dn, dz);
        check("mult_neg_done", {63'd0, dn}, 64'd1);
        check("mult_neg_hi", {32'd0, hi_o}, 64'h00000000FFFFFFFF);
        check("mult_neg_lo", {32'd0, lo_o}, 64'h00000000FFFFFFEB);

        run_op(2'b01, 32'h80000000, 32'h80000000, bc, dn, dz);
        check("mult_min_hi", {32'd0, hi_o}, 64'h0000000040000000);
        check("mult_min_lo", {32'd0, lo_o}, 64'd0);

`ifdef MDU_EARLY_TERM_EN
        exp_et_cycles = 2;
`else
        exp_et_cycles = 33;
`endif
        run_op(2'b00, 32'd5, 32'd1, bc, dn, dz);
        check("multu_small_cycles", 64'(bc), 64'(exp_et_cycles));
        check("multu_small_done", {63'd0, dn}, 64'd1);
        check("multu_small_hi", {32'd0, hi_o}, 64'd0);
        check("multu_small_lo", {32'd0, lo_o}, 64'd5);

        run_op(2'b11, 32'hFFFFFFF9, 32'd2, bc, dn, dz);
        check("div_neg_cycles", 64'(bc), 64'd33);
        check("div_neg_lo", {32'd0, lo_o}, 64'h00000000FFFFFFFD);
        check("div_neg_hi", {32'd0, hi_o}, 64'h00000000FFFFFFFF);

        run_op(2'b10, 32'd100, 32'd7, bc, dn, dz);
        check("divu_lo", {32'd0, lo_o}, 64'd14);
        check("divu_hi", {32'd0, hi_o}, 64'd2);
        check("divu_dz", {63'd0, dz}, 64'd0);

        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, bc, dn, dz);
        check("div_ovf_lo", {32'd0, lo_o}, 64'h0000000080000000);
        check("div_ovf_hi", {32'd0, hi_o}, 64'd0);
        check("div_ovf_dz", {63'd0, dz}, 64'd0);

        run_op(2'b10, 32'h00001234, 32'd0, bc, dn, dz);
        check("divu0_cycles", 64'(bc), 64'd33);
        check("divu0_done", {63'd0, dn}, 64'd1);
        check("divu0_dz", {63'd0, dz}, 64'd1);
        check("divu0_hi", {32'd0, hi_o}, 64'h0000000000001234);
        check("divu0_lo", {32'd0, lo_o}, 64'h00000000FFFFFFFF);
        @(negedge clk_i);
        check("divu0_dz_one_cycle", {63'd0, div_zero_o}, 64'd0);

        run_op(2'b11, 32'hFFFFFFFB, 32'd0, bc, dn, dz);
        check("div0_signed_dz", {63'd0, dz}, 64'd1);
        check("div0_signed_hi", {32'd0, hi_o}, 64'h00000000FFFFFFFB);
        check("div0_signed_lo", {32'd0, lo_o}, 64'h00000000FFFFFFFF);

        // MTLO in IDLE.
        @(negedge clk_i);
        lo_we_i = 1'b1;
        wdata_i = 32'h0000BEEF;
        @(negedge clk_i);
        lo_we_i = 1'b0;
        check("mtlo_idle", {32'd0, lo_o}, 64'h000000000000BEEF);
        $display("mtlo wdata=%h lo=%h", 32'h0000BEEF, lo_o);

        // DIVU 100/7 with an ignored start at edge 10 and MTHI during CALC.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'b10;
        src1_i  = 32'd100;
        src2_i  = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'b00;
        src1_i  = 32'd3;
        src2_i  = 32'd3;
        hi_we_i = 1'b1;
        wdata_i = 32'h000000AA;
        @(negedge clk_i);
        start_i = 1'b0;
        hi_we_i = 1'b0;
        check("mthi_calc_hi", {32'd0, hi_o}, 64'h00000000000000AA);
        check("mthi_calc_busy", {63'd0, busy_o}, 64'd1);
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (done_o) dcount++;
        end
        $display("ignored-start run done_pulses=%0d hi=%h lo=%h busy=%0b", dcount, hi_o, lo_o, busy_o);
        check("ignored_start_done_count", 64'(dcount), 64'd1);
        check("ignored_start_lo", {32'd0, lo_o}, 64'd14);
        check("ignored_start_hi", {32'd0, hi_o}, 64'd2);
        check("ignored_start_idle", {63'd0, busy_o}, 64'd0);

        // Asynchronous reset mid-CALC.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'b00;
        src1_i  = 32'hFFFFFFFF;
        src2_i  = 32'h00000002;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        check("rst_mid_hi", {32'd0, hi_o}, 64'd0);
        check("rst_mid_lo", {32'd0, lo_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) dcount++;
        end
        $display("after mid-op reset done_pulses=%0d busy=%0b", dcount, busy_o);
        check("rst_no_done", 64'(dcount), 64'd0);

        run_op(2'b10, 32'd100, 32'd7, bc, dn, dz);
        check("post_rst_cycles", 64'(bc), 64'd33);
        check("post_rst_done", {63'd0, dn}, 64'd1);
        check("post_rst_lo", {32'd0, lo_o}, 64'd14);
        check("post_rst_hi", {32'd0, hi_o}, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
